pic_rw_cmd_decoder: RTL and testbench
=====================================

Name: pic_rw_cmd_decoder

Overview:
Host-side read/write front end of the PIC, directly upstream of the control logic block. Synchronises the asynchronous host strobes (CS_n, WR_n, RD_n, A0) and classifies each completed write as ICW1–ICW4 or OCW1–OCW3 using the 8259A initialisation sequence rules. Presents the written byte on a held output with one-cycle valid pulses and 2-bit received-flag codes matching the control logic encodings. Produces the read-source select for host reads.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the strobe synchronisers (≥2)

Ports:
CLK  input  1  system clock
RESET  input  1  asynchronous, active-high reset
CS_n  input  1  chip select from host, active low, asynchronous
WR_n  input  1  write strobe, active low, asynchronous
RD_n  input  1  read strobe, active low, asynchronous
A0  input  1  host address bit
D_in  input  8  host data bus (write direction)
cmd_data  output  8  byte of last accepted command, held
icw_valid  output  1  one-cycle pulse: ICW accepted
ICW_RECEIVED_FLAG  output  2  00 ICW1, 01 ICW2, 10 ICW3, 11 ICW4; held
ocw_valid  output  1  one-cycle pulse: OCW accepted
OCW_RECEIVED  output  2  00 none, 01 OCW1, 10 OCW2, 11 OCW3; held
init_done  output  1  high in READY state
read_en  output  1  host read in progress (synchronised)
rd_sel  output  2  read source: 00 IRR, 01 ISR, 10 IMR

Behaviour:
- Reset (async): all outputs 0; synchroniser flops reset to 1 (inactive); capture flag cleared; state IDLE; OCW3 read-select memory = IRR.
- CS_n, WR_n, RD_n each pass through SYNC_STAGES flops plus one edge-detect flop. A0 and D_in are not synchronised; they are captured into cap_a0 and cap_d on every cycle where synced WR_n=0 and synced CS_n=0. Capturing also sets cap_seen.
- A write completes on the synced WR_n 0→1 edge with cap_seen=1. cap_seen clears on that edge. A write with CS_n inactive throughout is never captured and is ignored.
- Latency: the first CLK edge sampling WR_n=1 is edge 0. Decode registers update on edge SYNC_STAGES+1. The valid pulse is high for exactly one cycle after that edge. With the default, this is 3 edges.
- Host timing contract: WR_n low ≥ SYNC_STAGES+1 cycles; D_in and A0 stable for the whole low time.
- Classification rule, checked first in any state: cap_a0=0 and cap_d[4]=1 → ICW1.
- FSM states: IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
- ICW1, from any state:
  - icw_valid, flag 00.
  - Latch SNGL=cap_d[1] and IC4=cap_d[0].
  - OCW_RECEIVED←00; rd_sel memory←IRR; go to WAIT_ICW2.
- WAIT_ICW2 with A0=1: flag 01. Next state is WAIT_ICW3 if SNGL=0, else WAIT_ICW4 if IC4=1, else READY.
- WAIT_ICW3 with A0=1: flag 10. Next state is WAIT_ICW4 if IC4=1, else READY.
- WAIT_ICW4 with A0=1: flag 11, go to READY.
- In IDLE and in WAIT_ICWx, any write that is not ICW1 is ignored: no pulse, no state or output change.
- READY:
  - A0=1 → OCW1.
  - A0=0, D4=0, D3=0 → OCW2.
  - A0=0, D4=0, D3=1 → OCW3. If cap_d[1]=1 (RR), the read-select memory is set to ISR when cap_d[0]=1, else IRR. If RR=0, the memory is unchanged.
- cmd_data is updated only on an accepted command, in the same cycle as its valid pulse. Flags change only with their pulse. icw_valid and ocw_valid are never high together.
- init_done = (state==READY), registered.
- Read path: read_en = synced RD_n=0 and synced CS_n=0 and synced WR_n=1. rd_sel=10 (IMR) when A0=1 during the read, else the read-select memory. rd_sel is registered each cycle; its value when read_en=0 is don't-care, but it must still follow the same formula.
- RD and WR low simultaneously with CS: the write proceeds and read_en=0.
- RESET mid-write: the capture is discarded. If WR_n is still low when RESET releases, no capture occurs until the synced low is seen; a WR_n rise without cap_seen produces nothing.
- ICW1 received mid-sequence restarts the sequence; init_done drops on the same edge as the pulse.

Test Plan:
1. Single mode, no ICW4: write A0=0 D=0x12, then A0=1 D=0x20. Expect icw_valid twice with flags 00 then 01, cmd_data 0x12 then 0x20, init_done=1 after the 2nd pulse, state never WAIT_ICW3/4. Each pulse is exactly 1 cycle, 3 edges after WR_n rises.
2. Cascade with ICW4: writes 0x11, 0x08, 0x04, 0x01 (ICW2–4 with A0=1). Expect flags 00, 01, 10, 11 in order; init_done=1 only after the 4th write.
3. OCWs in READY: A0=1 0xFB → OCW_RECEIVED 01, cmd_data 0xFB. A0=0 0x20 → 10. A0=0 0x0B → 11, then a read with A0=0 gives read_en=1, rd_sel=01. A read with A0=1 gives rd_sel=10.
4. Ignored writes: in WAIT_ICW2 write A0=0 D=0x20 → no pulse, state unchanged. A write with CS_n=1 → no pulse. In IDLE write A0=1 → no pulse.
5. Reset mid-operation: assert RESET during WR_n low in WAIT_ICW3, release before WR_n rises. Expect all outputs 0, state IDLE, no pulse on the subsequent WR_n rise.
6. Re-init and contention: in READY write ICW1 0x13 → flag 00, OCW_RECEIVED 00, init_done 0, rd_sel memory IRR. RD_n and WR_n low together → read_en stays 0 and the write is accepted.

Source files
------------

// File: rtl/pic_rw_cmd_decoder_if.sv
// Host read/write bus and decoded command outputs of the PIC front end.
// Host side drives the strobes; the decoder drives the command outputs.
interface pic_rw_cmd_decoder_if;
  logic       CS_n;
  logic       WR_n;
  logic       RD_n;
  logic       A0;
  logic [7:0] D_in;
  logic [7:0] cmd_data;
  logic       icw_valid;
  logic [1:0] ICW_RECEIVED_FLAG;
  logic       ocw_valid;
  logic [1:0] OCW_RECEIVED;
  logic       init_done;
  logic       read_en;
  logic [1:0] rd_sel;

  modport master (
    output CS_n, WR_n, RD_n, A0, D_in,
    input  cmd_data, icw_valid, ICW_RECEIVED_FLAG,
    input  ocw_valid, OCW_RECEIVED, init_done,
    input  read_en, rd_sel
  );

  modport slave (
    input  CS_n, WR_n, RD_n, A0, D_in,
    output cmd_data, icw_valid, ICW_RECEIVED_FLAG,
    output ocw_valid, OCW_RECEIVED, init_done,
    output read_en, rd_sel
  );
endinterface

// File: rtl/pic_rw_cmd_decoder.sv
// PIC host read/write front end: strobe synchronisers, write capture,
// ICW/OCW classification with the 8259A init sequence, read-source select.
module pic_rw_cmd_decoder #(
  parameter int SYNC_STAGES = 2
) (
  input logic CLK,
  input logic RESET,
  pic_rw_cmd_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ICW2,
    WAIT_ICW3,
    WAIT_ICW4,
    READY
  } state_t;

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] wr_sync_q, wr_sync_d;
  logic [SYNC_STAGES-1:0] rd_sync_q, rd_sync_d;
  logic                   wr_prev_q, wr_prev_d;
  logic                   cs_s, wr_s, rd_s;
  logic                   cap_en, wr_rise;

  logic       cap_seen_q, cap_seen_d;
  logic       cap_a0_q, cap_a0_d;
  logic [7:0] cap_d_q, cap_d_d;
  logic       wr_done_q, wr_done_d;

  state_t     state_q, state_d;
  logic       sngl_q, sngl_d;
  logic       ic4_q, ic4_d;
  logic       rd_mem_q, rd_mem_d;
  logic [7:0] cmd_data_q, cmd_data_d;
  logic       icw_valid_q, icw_valid_d;
  logic [1:0] icw_flag_q, icw_flag_d;
  logic       ocw_valid_q, ocw_valid_d;
  logic [1:0] ocw_rcv_q, ocw_rcv_d;
  logic       init_done_q, init_done_d;
  logic       read_en_q, read_en_d;
  logic [1:0] rd_sel_q, rd_sel_d;
  logic       is_icw1;

  assign cs_s = cs_sync_q[SYNC_STAGES-1];
  assign wr_s = wr_sync_q[SYNC_STAGES-1];
  assign rd_s = rd_sync_q[SYNC_STAGES-1];

  // Shift the async strobes through the synchroniser chains
  always_comb begin
    cs_sync_d = {cs_sync_q[SYNC_STAGES-2:0], bus.CS_n};
    wr_sync_d = {wr_sync_q[SYNC_STAGES-2:0], bus.WR_n};
    rd_sync_d = {rd_sync_q[SYNC_STAGES-2:0], bus.RD_n};
    wr_prev_d = wr_s;
  end

  // Capture A0/D while the synced write is active; flag completion on rise
  always_comb begin
    cap_en     = ~wr_s & ~cs_s;
    wr_rise    = wr_s & ~wr_prev_q;
    cap_a0_d   = cap_a0_q;
    cap_d_d    = cap_d_q;
    cap_seen_d = cap_seen_q;
    if (cap_en) begin
      cap_a0_d   = bus.A0;
      cap_d_d    = bus.D_in;
      cap_seen_d = 1'b1;
    end else if (wr_rise) begin
      cap_seen_d = 1'b0;
    end
    wr_done_d = wr_rise & cap_seen_q;
  end

  // Classify a completed write and advance the init sequence
  always_comb begin
    state_d     = state_q;
    sngl_d      = sngl_q;
    ic4_d       = ic4_q;
    rd_mem_d    = rd_mem_q;
    cmd_data_d  = cmd_data_q;
    icw_valid_d = 1'b0;
    icw_flag_d  = icw_flag_q;
    ocw_valid_d = 1'b0;
    ocw_rcv_d   = ocw_rcv_q;
    is_icw1     = ~cap_a0_q & cap_d_q[4];
    if (wr_done_q) begin
      if (is_icw1) begin
        icw_valid_d = 1'b1;
        icw_flag_d  = 2'b00;
        cmd_data_d  = cap_d_q;
        sngl_d      = cap_d_q[1];
        ic4_d       = cap_d_q[0];
        ocw_rcv_d   = 2'b00;
        rd_mem_d    = 1'b0;
        state_d     = WAIT_ICW2;
      end else begin
        case (state_q)
          WAIT_ICW2: if (cap_a0_q) begin
            icw_valid_d = 1'b1;
            icw_flag_d  = 2'b01;
            cmd_data_d  = cap_d_q;
            if (!sngl_q)    state_d = WAIT_ICW3;
            else if (ic4_q) state_d = WAIT_ICW4;
            else            state_d = READY;
          end
          WAIT_ICW3: if (cap_a0_q) begin
            icw_valid_d = 1'b1;
            icw_flag_d  = 2'b10;
            cmd_data_d  = cap_d_q;
            state_d     = ic4_q ? WAIT_ICW4 : READY;
          end
          WAIT_ICW4: if (cap_a0_q) begin
            icw_valid_d = 1'b1;
            icw_flag_d  = 2'b11;
            cmd_data_d  = cap_d_q;
            state_d     = READY;
          end
          READY: begin
            ocw_valid_d = 1'b1;
            cmd_data_d  = cap_d_q;
            if (cap_a0_q) begin
              ocw_rcv_d = 2'b01;
            end else if (!cap_d_q[3]) begin
              ocw_rcv_d = 2'b10;
            end else begin
              ocw_rcv_d = 2'b11;
              if (cap_d_q[1]) rd_mem_d = cap_d_q[0];
            end
          end
          default: ;
        endcase
      end
    end
    init_done_d = (state_d == READY);
  end

  // Read qualification and source select; a concurrent write masks the read
  always_comb begin
    read_en_d = ~rd_s & ~cs_s & wr_s;
    rd_sel_d  = bus.A0 ? 2'b10 : {1'b0, rd_mem_q};
  end

  // Register all state; synchronisers idle high
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cs_sync_q   <= '1;
      wr_sync_q   <= '1;
      rd_sync_q   <= '1;
      wr_prev_q   <= 1'b1;
      cap_seen_q  <= 1'b0;
      cap_a0_q    <= 1'b0;
      cap_d_q     <= 8'h00;
      wr_done_q   <= 1'b0;
      state_q     <= IDLE;
      sngl_q      <= 1'b0;
      ic4_q       <= 1'b0;
      rd_mem_q    <= 1'b0;
      cmd_data_q  <= 8'h00;
      icw_valid_q <= 1'b0;
      icw_flag_q  <= 2'b00;
      ocw_valid_q <= 1'b0;
      ocw_rcv_q   <= 2'b00;
      init_done_q <= 1'b0;
      read_en_q   <= 1'b0;
      rd_sel_q    <= 2'b00;
    end else begin
      cs_sync_q   <= cs_sync_d;
      wr_sync_q   <= wr_sync_d;
      rd_sync_q   <= rd_sync_d;
      wr_prev_q   <= wr_prev_d;
      cap_seen_q  <= cap_seen_d;
      cap_a0_q    <= cap_a0_d;
      cap_d_q     <= cap_d_d;
      wr_done_q   <= wr_done_d;
      state_q     <= state_d;
      sngl_q      <= sngl_d;
      ic4_q       <= ic4_d;
      rd_mem_q    <= rd_mem_d;
      cmd_data_q  <= cmd_data_d;
      icw_valid_q <= icw_valid_d;
      icw_flag_q  <= icw_flag_d;
      ocw_valid_q <= ocw_valid_d;
      ocw_rcv_q   <= ocw_rcv_d;
      init_done_q <= init_done_d;
      read_en_q   <= read_en_d;
      rd_sel_q    <= rd_sel_d;
    end
  end

  assign bus.cmd_data          = cmd_data_q;
  assign bus.icw_valid         = icw_valid_q;
  assign bus.ICW_RECEIVED_FLAG = icw_flag_q;
  assign bus.ocw_valid         = ocw_valid_q;
  assign bus.OCW_RECEIVED      = ocw_rcv_q;
  assign bus.init_done         = init_done_q;
  assign bus.read_en           = read_en_q;
  assign bus.rd_sel            = rd_sel_q;

endmodule

// File: tb/tb_pic_rw_cmd_decoder.sv
// Directed self-checking bench for pic_rw_cmd_decoder.
// Linear host write/read sequence with hand-computed expectations.
module tb_pic_rw_cmd_decoder;

  logic CLK = 1'b0;
  logic RESET;
  int   tests = 0;
  int   fails = 0;

  pic_rw_cmd_decoder_if bus ();

  pic_rw_cmd_decoder #(.SYNC_STAGES(2)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // kind: 0 = no pulse expected, 1 = ICW pulse, 2 = OCW pulse
  task automatic wr(input logic a0, input logic [7:0] d,
                    input logic cs_n, input logic rd_n,
                    input int kind, input string tag);
    logic [5:0] iv, ov;
    logic       re;
    re = 1'b0;
    @(negedge CLK);
    bus.CS_n = cs_n;
    bus.A0   = a0;
    bus.D_in = d;
    bus.RD_n = rd_n;
    bus.WR_n = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      re |= bus.read_en;
    end
    bus.WR_n = 1'b1;
    bus.RD_n = 1'b1;
    iv = '0;
    ov = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      iv[k] = bus.icw_valid;
      ov[k] = bus.ocw_valid;
      re |= bus.read_en;
      if (k == 0) bus.CS_n = 1'b1;
    end
    chk({tag, "_icw_pulse"}, {26'd0, iv}, (kind == 1) ? 32'h08 : 32'h0);
    chk({tag, "_ocw_pulse"}, {26'd0, ov}, (kind == 2) ? 32'h08 : 32'h0);
    chk({tag, "_read_en"}, {31'd0, re}, 32'h0);
  endtask

  task automatic rd(input logic a0, input logic [1:0] sel,
                    input string tag);
    @(negedge CLK);
    bus.CS_n = 1'b0;
    bus.RD_n = 1'b0;
    bus.A0   = a0;
    repeat (4) @(negedge CLK);
    chk({tag, "_read_en"}, {31'd0, bus.read_en}, 32'h1);
    chk({tag, "_rd_sel"}, {30'd0, bus.rd_sel}, {30'd0, sel});
    bus.RD_n = 1'b1;
    bus.CS_n = 1'b1;
    repeat (4) @(negedge CLK);
    chk({tag, "_read_off"}, {31'd0, bus.read_en}, 32'h0);
  endtask

  task automatic chk_outs(input string tag, input logic [7:0] cmd,
                          input logic [1:0] iflag, input logic [1:0] orcv,
                          input logic done);
    chk({tag, "_cmd"}, {24'd0, bus.cmd_data}, {24'd0, cmd});
    chk({tag, "_iflag"}, {30'd0, bus.ICW_RECEIVED_FLAG}, {30'd0, iflag});
    chk({tag, "_ocw"}, {30'd0, bus.OCW_RECEIVED}, {30'd0, orcv});
    chk({tag, "_init"}, {31'd0, bus.init_done}, {31'd0, done});
  endtask

  initial begin
    logic [5:0] iv;
    RESET    = 1'b1;
    bus.CS_n = 1'b1;
    bus.WR_n = 1'b1;
    bus.RD_n = 1'b1;
    bus.A0   = 1'b0;
    bus.D_in = 8'h00;
    repeat (3) @(negedge CLK);
    chk_outs("rst", 8'h00, 2'b00, 2'b00, 1'b0);
    chk("rst_iv", {31'd0, bus.icw_valid}, 32'h0);
    chk("rst_ov", {31'd0, bus.ocw_valid}, 32'h0);
    chk("rst_re", {31'd0, bus.read_en}, 32'h0);
    chk("rst_sel", {30'd0, bus.rd_sel}, 32'h0);
    RESET = 1'b0;

    // single mode, no ICW4
    wr(1'b0, 8'h12, 1'b0, 1'b1, 1, "t1_icw1");
    chk_outs("t1_icw1", 8'h12, 2'b00, 2'b00, 1'b0);
    wr(1'b1, 8'h20, 1'b0, 1'b1, 1, "t1_icw2");
    chk_outs("t1_icw2", 8'h20, 2'b01, 2'b00, 1'b1);

    // cascade with ICW4
    wr(1'b0, 8'h11, 1'b0, 1'b1, 1, "t2_icw1");
    chk_outs("t2_icw1", 8'h11, 2'b00, 2'b00, 1'b0);
    wr(1'b1, 8'h08, 1'b0, 1'b1, 1, "t2_icw2");
    chk_outs("t2_icw2", 8'h08, 2'b01, 2'b00, 1'b0);
    wr(1'b1, 8'h04, 1'b0, 1'b1, 1, "t2_icw3");
    chk_outs("t2_icw3", 8'h04, 2'b10, 2'b00, 1'b0);
    wr(1'b1, 8'h01, 1'b0, 1'b1, 1, "t2_icw4");
    chk_outs("t2_icw4", 8'h01, 2'b11, 2'b00, 1'b1);

    // OCWs in READY and read select
    wr(1'b1, 8'hFB, 1'b0, 1'b1, 2, "t3_ocw1");
    chk_outs("t3_ocw1", 8'hFB, 2'b11, 2'b01, 1'b1);
    wr(1'b0, 8'h20, 1'b0, 1'b1, 2, "t3_ocw2");
    chk_outs("t3_ocw2", 8'h20, 2'b11, 2'b10, 1'b1);
    wr(1'b0, 8'h0B, 1'b0, 1'b1, 2, "t3_ocw3");
    chk_outs("t3_ocw3", 8'h0B, 2'b11, 2'b11, 1'b1);
    rd(1'b0, 2'b01, "t3_rd_isr");
    rd(1'b1, 2'b10, "t3_rd_imr");

    // ignored writes in WAIT_ICW2 and with CS_n inactive
    wr(1'b0, 8'h13, 1'b0, 1'b1, 1, "t4_icw1");
    chk_outs("t4_icw1", 8'h13, 2'b00, 2'b00, 1'b0);
    wr(1'b0, 8'h20, 1'b0, 1'b1, 0, "t4_ign_a0");
    chk_outs("t4_ign_a0", 8'h13, 2'b00, 2'b00, 1'b0);
    wr(1'b1, 8'h55, 1'b1, 1'b1, 0, "t4_ign_cs");
    chk_outs("t4_ign_cs", 8'h13, 2'b00, 2'b00, 1'b0);
    wr(1'b1, 8'h30, 1'b0, 1'b1, 1, "t4_icw2");
    chk_outs("t4_icw2", 8'h30, 2'b01, 2'b00, 1'b0);
    wr(1'b1, 8'h03, 1'b0, 1'b1, 1, "t4_icw4");
    chk_outs("t4_icw4", 8'h03, 2'b11, 2'b00, 1'b1);

    // reset in the middle of an ICW3 write
    wr(1'b0, 8'h11, 1'b0, 1'b1, 1, "t5_icw1");
    wr(1'b1, 8'h08, 1'b0, 1'b1, 1, "t5_icw2");
    chk_outs("t5_icw2", 8'h08, 2'b01, 2'b00, 1'b0);
    @(negedge CLK);
    bus.CS_n = 1'b0;
    bus.A0   = 1'b1;
    bus.D_in = 8'h04;
    bus.WR_n = 1'b0;
    repeat (4) @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    chk_outs("t5_inrst", 8'h00, 2'b00, 2'b00, 1'b0);
    RESET    = 1'b0;
    bus.WR_n = 1'b1;
    iv = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      iv[k] = bus.icw_valid | bus.ocw_valid;
      if (k == 0) bus.CS_n = 1'b1;
    end
    chk("t5_no_pulse", {26'd0, iv}, 32'h0);
    chk_outs("t5_after", 8'h00, 2'b00, 2'b00, 1'b0);
    wr(1'b1, 8'h20, 1'b0, 1'b1, 0, "t5_idle_ign");
    chk_outs("t5_idle_ign", 8'h00, 2'b00, 2'b00, 1'b0);

    // re-init from READY and RD/WR contention
    wr(1'b0, 8'h12, 1'b0, 1'b1, 1, "t6_icw1");
    wr(1'b1, 8'h20, 1'b0, 1'b1, 1, "t6_icw2");
    wr(1'b0, 8'h0B, 1'b0, 1'b1, 2, "t6_ocw3");
    chk_outs("t6_ocw3", 8'h0B, 2'b01, 2'b11, 1'b1);
    wr(1'b0, 8'h13, 1'b0, 1'b1, 1, "t6_reinit");
    chk_outs("t6_reinit", 8'h13, 2'b00, 2'b00, 1'b0);
    rd(1'b0, 2'b00, "t6_rd_irr");
    wr(1'b1, 8'h20, 1'b0, 1'b0, 1, "t6_contend");
    chk_outs("t6_contend", 8'h20, 2'b01, 2'b00, 1'b0);
    wr(1'b1, 8'h01, 1'b0, 1'b1, 1, "t6_icw4");
    chk_outs("t6_icw4", 8'h01, 2'b11, 2'b00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
